issue_ctrl: RTL and testbench

ISSUE_CTRL -- requirements
Module: issue_ctrl

---
 rtl/issue_ctrl_if.sv | 53 +++++
 rtl/issue_ctrl.sv | 130 +++++++++++++
 tb/tb_issue_ctrl.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/issue_ctrl_if.sv
// Decode-to-issue handshake bundle for issue_ctrl.
// The controller uses the slave modport; the decode/execute side uses master.
interface issue_ctrl_if #(
    parameter int unsigned OPB_W = 10,
    parameter int unsigned CNT_W = 16
) ();
    logic             i_dec_val;
    logic             o_dec_rdy;
    logic [OPB_W-1:0] i_dec_opb;
    logic [3:0]       i_dec_usele;
    logic             i_dec_rs1_ren;
    logic             i_dec_rs2_ren;
    logic             i_dec_rd_wen;
    logic [4:0]       i_dec_rs1_idx;
    logic [4:0]       i_dec_rs2_idx;
    logic [4:0]       i_dec_rd_idx;
    logic [31:0]      i_dec_im;
    logic             i_dec_ilgl;

    logic [3:0]       o_iss_val;
    logic [3:0]       i_iss_rdy;
    logic [OPB_W-1:0] o_iss_opb;
    logic [4:0]       o_iss_rs1_idx;
    logic [4:0]       o_iss_rs2_idx;
    logic [4:0]       o_iss_rd_idx;
    logic             o_iss_rd_wen;
    logic [31:0]      o_iss_im;

    logic             i_wb_val;
    logic [4:0]       i_wb_idx;
    logic             i_flush;
    logic             o_exc_ilgl;
    logic             o_sb_busy;
    logic [CNT_W-1:0] o_stall_cnt;

    modport slave (
        input  i_dec_val, i_dec_opb, i_dec_usele, i_dec_rs1_ren, i_dec_rs2_ren,
               i_dec_rd_wen, i_dec_rs1_idx, i_dec_rs2_idx, i_dec_rd_idx,
               i_dec_im, i_dec_ilgl, i_iss_rdy, i_wb_val, i_wb_idx, i_flush,
        output o_dec_rdy, o_iss_val, o_iss_opb, o_iss_rs1_idx, o_iss_rs2_idx,
               o_iss_rd_idx, o_iss_rd_wen, o_iss_im, o_exc_ilgl, o_sb_busy,
               o_stall_cnt
    );

    modport master (
        output i_dec_val, i_dec_opb, i_dec_usele, i_dec_rs1_ren, i_dec_rs2_ren,
               i_dec_rd_wen, i_dec_rs1_idx, i_dec_rs2_idx, i_dec_rd_idx,
               i_dec_im, i_dec_ilgl, i_iss_rdy, i_wb_val, i_wb_idx, i_flush,
        input  o_dec_rdy, o_iss_val, o_iss_opb, o_iss_rs1_idx, o_iss_rs2_idx,
               o_iss_rd_idx, o_iss_rd_wen, o_iss_im, o_exc_ilgl, o_sb_busy,
               o_stall_cnt
    );
endinterface

// File: rtl/issue_ctrl.sv
// Single-entry issue controller: holds one decoded op, checks it against a
// register scoreboard, and issues it to the selected execution unit.
module issue_ctrl #(
    parameter int unsigned OPB_W = 10,
    parameter int unsigned CNT_W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    issue_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {S_EMPTY, S_FULL, S_DRAIN} state_t;

    typedef struct packed {
        logic [OPB_W-1:0] opb;
        logic [3:0]       usele;
        logic             rs1_ren;
        logic             rs2_ren;
        logic             rd_wen;
        logic [4:0]       rs1_idx;
        logic [4:0]       rs2_idx;
        logic [4:0]       rd_idx;
        logic [31:0]      im;
        logic             ilgl;
    } entry_t;

    state_t           state_q, state_d;
    entry_t           ent_q, ent_d;
    logic [31:0]      pend_q, pend_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    logic [31:0] wb_mask;
    logic [31:0] eff;
    logic        hazard;
    logic        bad;
    logic [3:0]  iss_val;
    logic        fire;
    logic        rdy;
    logic        take;
    logic        exc;

    // Writeback landing this cycle is already visible to the hazard check.
    assign wb_mask = bus.i_wb_val ? (32'd1 << bus.i_wb_idx) : 32'd0;
    assign eff     = pend_q & ~wb_mask;

    assign hazard = (ent_q.rs1_ren & eff[ent_q.rs1_idx])
                  | (ent_q.rs2_ren & eff[ent_q.rs2_idx])
                  | (ent_q.rd_wen  & eff[ent_q.rd_idx]);

    // An entry with no unit selected can never issue, so it drains like ilgl.
    assign bad     = ent_q.ilgl | (ent_q.usele == 4'd0);
    assign iss_val = ((state_q == S_FULL) && !bad && !hazard && !bus.i_flush)
                     ? ent_q.usele : 4'd0;
    assign fire    = |(iss_val & bus.i_iss_rdy);
    assign rdy     = !bus.i_flush
                   && ((state_q == S_EMPTY) || ((state_q == S_FULL) && fire));
    assign take    = bus.i_dec_val & rdy;
    assign exc     = (state_q == S_DRAIN) && (eff == 32'd0) && !bus.i_flush;

    always_comb begin
        state_d = state_q;
        ent_d   = ent_q;
        pend_d  = eff;
        stall_d = stall_q;

        if (take) begin
            ent_d.opb     = bus.i_dec_opb;
            ent_d.usele   = bus.i_dec_usele;
            ent_d.rs1_ren = bus.i_dec_rs1_ren;
            ent_d.rs2_ren = bus.i_dec_rs2_ren;
            ent_d.rd_wen  = bus.i_dec_rd_wen;
            ent_d.rs1_idx = bus.i_dec_rs1_idx;
            ent_d.rs2_idx = bus.i_dec_rs2_idx;
            ent_d.rd_idx  = bus.i_dec_rd_idx;
            ent_d.im      = bus.i_dec_im;
            ent_d.ilgl    = bus.i_dec_ilgl;
        end

        // Issue reserves the destination; applied after the clear so set wins.
        if (fire && ent_q.rd_wen && (ent_q.rd_idx != 5'd0)) begin
            pend_d[ent_q.rd_idx] = 1'b1;
        end

        if ((state_q == S_FULL) && !bad && !fire && (stall_q != '1)) begin
            stall_d = stall_q + CNT_W'(1);
        end

        case (state_q)
            S_EMPTY: begin
                if (take) state_d = S_FULL;
            end
            S_FULL: begin
                if (bus.i_flush)  state_d = S_EMPTY;
                else if (bad)     state_d = S_DRAIN;
                else if (fire)    state_d = take ? S_FULL : S_EMPTY;
            end
            S_DRAIN: begin
                if (bus.i_flush || (eff == 32'd0)) state_d = S_EMPTY;
            end
            default: state_d = S_EMPTY;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_EMPTY;
            ent_q   <= '0;
            pend_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            ent_q   <= ent_d;
            pend_q  <= pend_d;
            stall_q <= stall_d;
        end
    end

    assign bus.o_dec_rdy     = rdy;
    assign bus.o_iss_val     = iss_val;
    assign bus.o_iss_opb     = ent_q.opb;
    assign bus.o_iss_rs1_idx = ent_q.rs1_idx;
    assign bus.o_iss_rs2_idx = ent_q.rs2_idx;
    assign bus.o_iss_rd_idx  = ent_q.rd_idx;
    assign bus.o_iss_rd_wen  = ent_q.rd_wen;
    assign bus.o_iss_im      = ent_q.im;
    assign bus.o_exc_ilgl    = exc;
    assign bus.o_sb_busy     = |pend_q;
    assign bus.o_stall_cnt   = stall_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// Bench for issue_ctrl: directed scenarios with literal expectations, then
// random traffic checked every cycle against a transaction-level model.
module tb_issue_ctrl;
    localparam int unsigned OPB_W  = 10;
    localparam int unsigned CNT_W  = 4;
    localparam int          CNTMAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    issue_ctrl_if #(.OPB_W(OPB_W), .CNT_W(CNT_W)) bus ();
    issue_ctrl #(.OPB_W(OPB_W), .CNT_W(CNT_W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [OPB_W-1:0] opb;
        logic [3:0]       usele;
        logic             r1e, r2e, rdw;
        logic [4:0]       r1, r2, rd;
        logic [31:0]      im;
        logic             ilgl;
    } op_t;

    op_t         m_ent;
    bit          m_full  = 0;     // an op is waiting to issue
    bit          m_drain = 0;     // an illegal op waits for outstanding writes
    bit          m_out [32];      // register has a write in flight
    int          m_cnt   = 0;

    bit          still_out [32];
    bit          any_out, bad_op, blocked, e_fire, e_rdy, e_exc, tk;
    logic [3:0]  e_val;

    always @(negedge clk) begin
        if (rst) begin
            m_full = 0; m_drain = 0; m_cnt = 0;
            foreach (m_out[i]) m_out[i] = 0;
            chk("rst_iss_val", 64'(bus.o_iss_val), 64'd0);
            chk("rst_exc", 64'(bus.o_exc_ilgl), 64'd0);
            chk("rst_busy", 64'(bus.o_sb_busy), 64'd0);
            chk("rst_stall", 64'(bus.o_stall_cnt), 64'd0);
        end else begin
            any_out = 0;
            foreach (m_out[i]) begin
                still_out[i] = m_out[i] && !(bus.i_wb_val && bus.i_wb_idx == 5'(i));
                if (still_out[i]) any_out = 1;
            end
            bad_op  = m_ent.ilgl || (m_ent.usele == 4'd0);
            blocked = (m_ent.r1e && still_out[m_ent.r1]) || (m_ent.r2e && still_out[m_ent.r2])
                   || (m_ent.rdw && still_out[m_ent.rd]);
            e_val   = (m_full && !bad_op && !blocked && !bus.i_flush) ? m_ent.usele : 4'd0;
            e_fire  = (e_val & bus.i_iss_rdy) != 4'd0;
            e_rdy   = !bus.i_flush && ((!m_full && !m_drain) || (m_full && e_fire));
            e_exc   = m_drain && !any_out && !bus.i_flush;
            tk      = bus.i_dec_val && e_rdy;

            chk("iss_val", 64'(bus.o_iss_val), 64'(e_val));
            chk("dec_rdy", 64'(bus.o_dec_rdy), 64'(e_rdy));
            chk("exc_ilgl", 64'(bus.o_exc_ilgl), 64'(e_exc));
            chk("sb_busy", 64'(bus.o_sb_busy), 64'(m_out.or() != 0));
            chk("stall_cnt", 64'(bus.o_stall_cnt), 64'(m_cnt));
            if (e_val != 4'd0) begin
                chk("iss_opb", 64'(bus.o_iss_opb), 64'(m_ent.opb));
                chk("iss_rs1", 64'(bus.o_iss_rs1_idx), 64'(m_ent.r1));
                chk("iss_rs2", 64'(bus.o_iss_rs2_idx), 64'(m_ent.r2));
                chk("iss_rd", 64'(bus.o_iss_rd_idx), 64'(m_ent.rd));
                chk("iss_rdw", 64'(bus.o_iss_rd_wen), 64'(m_ent.rdw));
                chk("iss_im", 64'(bus.o_iss_im), 64'(m_ent.im));
            end

            // advance one clock
            if (m_full && !bad_op && !e_fire && m_cnt < CNTMAX) m_cnt++;
            foreach (m_out[i]) m_out[i] = still_out[i];
            if (e_fire && m_ent.rdw && m_ent.rd != 5'd0) m_out[m_ent.rd] = 1;
            if (bus.i_flush) begin
                m_full = 0; m_drain = 0;
            end else if (m_drain) begin
                if (!any_out) m_drain = 0;
            end else if (m_full) begin
                if (bad_op) begin m_full = 0; m_drain = 1; end
                else if (e_fire) m_full = tk;
            end else begin
                m_full = tk;
            end
            if (tk) begin
                m_ent.opb = bus.i_dec_opb;   m_ent.usele = bus.i_dec_usele;
                m_ent.r1e = bus.i_dec_rs1_ren; m_ent.r2e = bus.i_dec_rs2_ren;
                m_ent.rdw = bus.i_dec_rd_wen;  m_ent.r1 = bus.i_dec_rs1_idx;
                m_ent.r2  = bus.i_dec_rs2_idx; m_ent.rd = bus.i_dec_rd_idx;
                m_ent.im  = bus.i_dec_im;      m_ent.ilgl = bus.i_dec_ilgl;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic clr();
        bus.i_dec_val = 0; bus.i_dec_opb = '0; bus.i_dec_usele = 4'd0;
        bus.i_dec_rs1_ren = 0; bus.i_dec_rs2_ren = 0; bus.i_dec_rd_wen = 0;
        bus.i_dec_rs1_idx = 5'd0; bus.i_dec_rs2_idx = 5'd0; bus.i_dec_rd_idx = 5'd0;
        bus.i_dec_im = 32'd0; bus.i_dec_ilgl = 0;
        bus.i_iss_rdy = 4'hF; bus.i_wb_val = 0; bus.i_wb_idx = 5'd0; bus.i_flush = 0;
    endtask

    task automatic offer(input logic [3:0] us, input logic r1e, input logic [4:0] r1,
                         input logic r2e, input logic [4:0] r2,
                         input logic rdw, input logic [4:0] rd, input logic il);
        bus.i_dec_val = 1; bus.i_dec_usele = us;
        bus.i_dec_rs1_ren = r1e; bus.i_dec_rs1_idx = r1;
        bus.i_dec_rs2_ren = r2e; bus.i_dec_rs2_idx = r2;
        bus.i_dec_rd_wen = rdw;  bus.i_dec_rd_idx = rd;
        bus.i_dec_opb = OPB_W'($urandom); bus.i_dec_im = $urandom; bus.i_dec_ilgl = il;
    endtask

    task automatic tick();
        @(posedge clk); #1; clr();
    endtask

    task automatic wb(input logic [4:0] idx);
        bus.i_wb_val = 1; bus.i_wb_idx = idx;
    endtask

    initial begin
        clr();
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        #2;
        chk("post_rst_rdy", 64'(bus.o_dec_rdy), 64'd1);
        chk("post_rst_stall", 64'(bus.o_stall_cnt), 64'd0);

        // back-to-back independent ALU ops, destination x0
        bus.i_iss_rdy = 4'b0001;
        offer(4'b0001, 0, 5'd0, 0, 5'd0, 1, 5'd0, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            bus.i_iss_rdy = 4'b0001;
            offer(4'b0001, 1, 5'(i + 1), 1, 5'(i + 2), 1, 5'd0, 0);
            #2;
            chk("b2b_iss", 64'(bus.o_iss_val), 64'h1);
            chk("b2b_rdy", 64'(bus.o_dec_rdy), 64'd1);
            chk("x0_busy", 64'(bus.o_sb_busy), 64'd0);
        end
        tick(); #2;
        chk("b2b_last", 64'(bus.o_iss_val), 64'h1);
        tick(); #2;
        chk("b2b_stall", 64'(bus.o_stall_cnt), 64'd0);
        chk("b2b_busy", 64'(bus.o_sb_busy), 64'd0);

        // RAW stall on x5
        offer(4'b0001, 0, 5'd0, 0, 5'd0, 1, 5'd5, 0);
        tick();
        offer(4'b0010, 1, 5'd5, 0, 5'd0, 0, 5'd0, 0);
        #2; chk("raw_a_iss", 64'(bus.o_iss_val), 64'h1);
        tick();
        for (int k = 0; k < 3; k++) begin
            #2;
            chk("raw_stall_iss", 64'(bus.o_iss_val), 64'h0);
            chk("raw_busy", 64'(bus.o_sb_busy), 64'd1);
            tick();
        end
        wb(5'd5);
        #2; chk("raw_wb_iss", 64'(bus.o_iss_val), 64'h2);
        tick(); #2;
        chk("raw_stall_cnt", 64'(bus.o_stall_cnt), 64'd3);
        chk("raw_busy_clr", 64'(bus.o_sb_busy), 64'd0);

        // issue setting x7 while x7 writes back in the same cycle
        offer(4'b0001, 0, 5'd0, 0, 5'd0, 1, 5'd7, 0);
        tick();
        wb(5'd7);
        #2; chk("setclr_iss", 64'(bus.o_iss_val), 64'h1);
        tick(); #2;
        chk("setclr_busy", 64'(bus.o_sb_busy), 64'd1);
        wb(5'd7);
        tick(); #2;
        chk("setclr_clear", 64'(bus.o_sb_busy), 64'd0);

        // illegal op behind pending x3
        offer(4'b0001, 0, 5'd0, 0, 5'd0, 1, 5'd3, 0);
        tick();
        offer(4'b0001, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1);
        tick(); #2;
        chk("ilgl_no_iss", 64'(bus.o_iss_val), 64'h0);
        chk("ilgl_no_exc0", 64'(bus.o_exc_ilgl), 64'd0);
        tick(); #2;
        chk("ilgl_drain_exc", 64'(bus.o_exc_ilgl), 64'd0);
        chk("ilgl_drain_rdy", 64'(bus.o_dec_rdy), 64'd0);
        tick(); #2;
        chk("ilgl_drain_exc2", 64'(bus.o_exc_ilgl), 64'd0);
        tick();
        wb(5'd3);
        #2; chk("ilgl_exc_pulse", 64'(bus.o_exc_ilgl), 64'd1);
        tick(); #2;
        chk("ilgl_exc_once", 64'(bus.o_exc_ilgl), 64'd0);
        chk("ilgl_after_rdy", 64'(bus.o_dec_rdy), 64'd1);

        // flush while FULL and blocked on x4
        offer(4'b0001, 0, 5'd0, 0, 5'd0, 1, 5'd4, 0);
        tick();
        offer(4'b0100, 0, 5'd0, 1, 5'd4, 0, 5'd0, 0);
        tick();
        bus.i_flush = 1;
        #2;
        chk("flush_no_iss", 64'(bus.o_iss_val), 64'h0);
        chk("flush_rdy", 64'(bus.o_dec_rdy), 64'd0);
        tick(); #2;
        chk("flush_empty_rdy", 64'(bus.o_dec_rdy), 64'd1);
        chk("flush_pend_kept", 64'(bus.o_sb_busy), 64'd1);
        chk("flush_no_iss2", 64'(bus.o_iss_val), 64'h0);
        wb(5'd4);
        tick();

        // reset while draining an illegal op
        offer(4'b0001, 0, 5'd0, 0, 5'd0, 1, 5'd6, 0);
        tick();
        offer(4'b0010, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1);
        tick(); tick();
        rst = 1;
        #2;
        chk("midrst_exc", 64'(bus.o_exc_ilgl), 64'd0);
        chk("midrst_busy", 64'(bus.o_sb_busy), 64'd0);
        tick();
        rst = 0;

        // random traffic
        for (int n = 0; n < 4000; n++) begin
            tick();
            rst = ($urandom_range(0, 499) == 0);
            bus.i_dec_val     = ($urandom_range(0, 9) < 7);
            bus.i_dec_usele   = ($urandom_range(0, 29) == 0) ? 4'd0 : 4'(1 << $urandom_range(0, 3));
            bus.i_dec_ilgl    = ($urandom_range(0, 29) == 0);
            bus.i_dec_rs1_ren = 1'($urandom);
            bus.i_dec_rs2_ren = 1'($urandom);
            bus.i_dec_rd_wen  = 1'($urandom);
            bus.i_dec_rs1_idx = 5'($urandom_range(0, 7));
            bus.i_dec_rs2_idx = 5'($urandom_range(0, 7));
            bus.i_dec_rd_idx  = 5'($urandom_range(0, 7));
            bus.i_dec_opb     = OPB_W'($urandom);
            bus.i_dec_im      = $urandom;
            bus.i_iss_rdy     = 4'($urandom);
            bus.i_wb_val      = ($urandom_range(0, 9) < 4);
            bus.i_wb_idx      = 5'($urandom_range(0, 7));
            bus.i_flush       = ($urandom_range(0, 29) == 0);
        end
        tick();
        rst = 0;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
